// File: rtl/wo_reg_bank_arbiter.sv
// Round-robin write arbiter in front of a bank of write-once 16-bit registers.
// Each granted write is committed only if the target register is in range and unlocked.
module wo_reg_bank_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       Clk,
    input  logic                       ip_resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       resp_valid,
    output logic                       resp_err,
    output logic [ID_W-1:0]            resp_id,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS-1:0]        lock_status
);

    // state | meaning
    // IDLE  | pick round-robin winner, latch its addr/data/id, pulse gnt
    // CHECK | decide rejection: address out of range or register locked
    // EXEC  | commit write if accepted, raise resp_valid with resp_err
    // RESP  | drop resp_valid, return to arbitration
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ID_W:0]   NUM_REQ_C  = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         rr_nxt;

    logic [ADDR_W-1:0]       addr_l;
    logic [DATA_W-1:0]       data_l;
    logic [ID_W-1:0]         id_l;
    logic                    err_l;
    logic                    err_nxt;

    logic [DATA_W-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0]     lock;

    logic                    found;
    logic [ID_W-1:0]         winner;
    logic [ID_W:0]           cand;
    logic [ID_W-1:0]         cand_id;

    logic [NUM_REQ-1:0]      gnt_nxt;
    logic                    resp_valid_nxt;
    logic                    resp_err_nxt;
    logic [ID_W-1:0]         resp_id_nxt;
    logic                    latch_en;
    logic                    commit_en;
    logic                    addr_l_ok;
    logic                    lock_hit;

    // First asserted request at or after rr_ptr, wrapping upward.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        cand    = '0;
        cand_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            cand_id = cand[ID_W-1:0];
            if (!found && req[cand_id]) begin
                found  = 1'b1;
                winner = cand_id;
            end
        end
    end

    assign rr_nxt    = (winner == LAST_ID) ? '0 : winner + 1'b1;
    assign addr_l_ok = ({1'b0, addr_l} < NUM_REGS_C);
    assign lock_hit  = addr_l_ok ? lock[addr_l] : 1'b1;

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = '0;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = resp_err;
        resp_id_nxt    = resp_id;
        err_nxt        = err_l;
        latch_en       = 1'b0;
        commit_en      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    latch_en  = 1'b1;
                    gnt_nxt   = NUM_REQ'(1) << winner;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                err_nxt   = lock_hit;
                state_nxt = EXEC;
            end
            EXEC: begin
                commit_en      = !err_l;
                resp_valid_nxt = 1'b1;
                resp_err_nxt   = err_l;
                resp_id_nxt    = id_l;
                state_nxt      = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!ip_resetn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_id    <= '0;
            addr_l     <= '0;
            data_l     <= '0;
            id_l       <= '0;
            err_l      <= 1'b0;
            lock       <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_id    <= resp_id_nxt;
            err_l      <= err_nxt;
            if (latch_en) begin
                addr_l <= req_addr[winner*ADDR_W +: ADDR_W];
                data_l <= req_data[winner*DATA_W +: DATA_W];
                id_l   <= winner;
                rr_ptr <= rr_nxt;
            end
            // Bit 0 of the written data is the lock; it is not stored in the register body.
            if (commit_en) begin
                regs[addr_l] <= {data_l[DATA_W-1:1], 1'b0};
                lock[addr_l] <= data_l[0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < NUM_REGS_C) begin
            rd_data = {regs[rd_addr][DATA_W-1:1], lock[rd_addr]};
        end
    end

    assign lock_status = lock;

endmodule

// File: tb/tb_wo_reg_bank_arbiter.sv
// Self-checking bench for wo_reg_bank_arbiter against a behavioural bank/arbiter model.
module tb_wo_reg_bank_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;

    logic                      Clk = 1'b0;
    logic                      ip_resetn;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      resp_valid;
    logic                      resp_err;
    logic [1:0]                resp_id;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REGS-1:0]       lock_status;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_reg  [NUM_REGS];
    logic        m_lock [NUM_REGS];
    int          m_rr;
    logic [3:0]  last_gnt;

    always #5 Clk = ~Clk;

    wo_reg_bank_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W)
    ) dut (
        .Clk        (Clk),
        .ip_resetn  (ip_resetn),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_id    (resp_id),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .lock_status(lock_status)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_reg[i]  = 16'h0000;
            m_lock[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    function automatic logic [15:0] exp_rd(input int a);
        if (a >= NUM_REGS) return 16'h0000;
        return {m_reg[a][15:1], m_lock[a]};
    endfunction

    function automatic logic [7:0] exp_locks();
        logic [7:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_lock[i];
        return v;
    endfunction

    task automatic set_req(input int i, input logic [2:0] a, input logic [15:0] d);
        req[i]                = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset;
        ip_resetn = 1'b0;
        req       = '0;
        tick;
        tick;
        ip_resetn = 1'b1;
        model_reset();
    endtask

    // One full transaction from the IDLE sample to the end of RESP.
    task automatic serve_one;
        int          w;
        int          idx;
        logic [2:0]  a;
        logic [15:0] d;
        logic        e;
        w = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_rr + k) % NUM_REQ;
            if (w < 0 && req[idx]) w = idx;
        end
        a = req_addr[w*ADDR_W +: ADDR_W];
        d = req_data[w*DATA_W +: DATA_W];
        rd_addr = a;
        tick;
        checks++;
        if (gnt !== 4'(1 << w)) begin
            errors++;
            $display("FAIL gnt: got %b expected %b", gnt, 4'(1 << w));
        end
        last_gnt = gnt;
        req[w] = 1'b0;
        // Later changes on the winner's bus must not affect the latched write.
        req_addr[w*ADDR_W +: ADDR_W] = 3'($urandom);
        req_data[w*DATA_W +: DATA_W] = 16'($urandom);
        m_rr = (w + 1) % NUM_REQ;
        e = (a >= NUM_REGS) || m_lock[a];
        tick;
        checks++;
        if (gnt !== 4'b0000 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL check_phase: gnt %b resp_valid %b expected 0000 0", gnt, resp_valid);
        end
        checks++;
        if (rd_data !== exp_rd(a)) begin
            errors++;
            $display("FAIL precommit_rd: addr %0d got %h expected %h", a, rd_data, exp_rd(a));
        end
        if (!e) begin
            m_reg[a]  = d & 16'hFFFE;
            m_lock[a] = d[0];
        end
        tick;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== e || resp_id !== 2'(w)) begin
            errors++;
            $display("FAIL resp: valid %b err %b id %0d expected 1 %b %0d",
                     resp_valid, resp_err, resp_id, e, w);
        end
        checks++;
        if (rd_data !== exp_rd(a)) begin
            errors++;
            $display("FAIL commit_rd: addr %0d got %h expected %h", a, rd_data, exp_rd(a));
        end
        checks++;
        if (lock_status !== exp_locks()) begin
            errors++;
            $display("FAIL lock_status: got %b expected %b", lock_status, exp_locks());
        end
        tick;
        checks++;
        if (resp_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL resp_phase: resp_valid %b gnt %b expected 0 0000", resp_valid, gnt);
        end
    endtask

    task automatic check_rd(input logic [2:0] a, input logic [15:0] expv, input string name);
        rd_addr = a;
        #1;
        checks++;
        if (rd_data !== expv) begin
            errors++;
            $display("FAIL %s: addr %0d got %h expected %h", name, a, rd_data, expv);
        end
    endtask

    task automatic test_reset;
        ip_resetn = 1'b0;
        req       = 4'b1111;
        tick;
        tick;
        checks++;
        if (gnt !== 4'b0000 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt %b resp_valid %b expected 0000 0", gnt, resp_valid);
        end
        checks++;
        if (lock_status !== 8'h00) begin
            errors++;
            $display("FAIL reset_locks: got %b expected 00000000", lock_status);
        end
        for (int a = 0; a < NUM_REGS; a++) begin
            check_rd(3'(a), 16'h0000, "reset_rd");
        end
        req       = '0;
        ip_resetn = 1'b1;
        model_reset();
        tick;
    endtask

    task automatic test_single_write;
        set_req(0, 3'd3, 16'hABCD);
        serve_one();
        check_rd(3'd3, 16'hABCD, "single_rd");
        checks++;
        if (lock_status[3] !== 1'b1 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_lock: lock %b id %0d expected 1 0", lock_status[3], resp_id);
        end
    endtask

    task automatic test_write_once;
        set_req(0, 3'd3, 16'h1234);
        serve_one();
        checks++;
        if (resp_err !== 1'b1) begin
            errors++;
            $display("FAIL write_once_err: got %b expected 1", resp_err);
        end
        check_rd(3'd3, 16'hABCD, "write_once_rd");
    endtask

    task automatic test_unlocked_rewrite;
        set_req(2, 3'd5, 16'h00F0);
        serve_one();
        check_rd(3'd5, 16'h00F0, "rewrite_first_rd");
        set_req(2, 3'd5, 16'h0F01);
        serve_one();
        checks++;
        if (resp_err !== 1'b0 || lock_status[5] !== 1'b1) begin
            errors++;
            $display("FAIL rewrite_second: err %b lock %b expected 0 1", resp_err, lock_status[5]);
        end
        check_rd(3'd5, 16'h0F01, "rewrite_final_rd");
    endtask

    task automatic test_round_robin;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(2 * i), 16'h1110 + 16'(i));
        for (int g = 0; g < NUM_REQ; g++) begin
            serve_one();
            checks++;
            if (last_gnt !== 4'(1 << g)) begin
                errors++;
                $display("FAIL rr_order: step %0d got %b expected %b", g, last_gnt, 4'(1 << g));
            end
        end
        set_req(0, 3'd7, 16'h2220);
        set_req(3, 3'd1, 16'h3330);
        serve_one();
        checks++;
        if (last_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rr_1001_first: got %b expected 0001", last_gnt);
        end
        serve_one();
        checks++;
        if (last_gnt !== 4'b1000) begin
            errors++;
            $display("FAIL rr_1001_second: got %b expected 1000", last_gnt);
        end
    endtask

    task automatic test_random;
        logic [15:0] d;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    d = 16'($urandom);
                    d[0] = ($urandom_range(0, 3) == 0);
                    set_req(i, 3'($urandom_range(0, NUM_REGS - 1)), d);
                end
            end
            if (req == 4'b0000) begin
                set_req(int'($urandom_range(0, NUM_REQ - 1)), 3'($urandom_range(0, NUM_REGS - 1)),
                        16'($urandom));
            end
            serve_one();
        end
        while (req != 4'b0000) serve_one();
        tick;
        tick;
        checks++;
        if (gnt !== 4'b0000 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: gnt %b resp_valid %b expected 0000 0", gnt, resp_valid);
        end
        for (int a = 0; a < NUM_REGS; a++) check_rd(3'(a), exp_rd(a), "random_final_rd");
    endtask

    task automatic test_mid_reset;
        set_req(0, 3'd1, 16'hFFFF);
        tick;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_gnt: got %b expected 0001", gnt);
        end
        req[0] = 1'b0;
        tick;
        ip_resetn = 1'b0;
        rd_addr   = 3'd1;
        tick;
        checks++;
        if (resp_valid !== 1'b0 || lock_status[1] !== 1'b0 || rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_abort: resp_valid %b lock %b rd %h expected 0 0 0000",
                     resp_valid, lock_status[1], rd_data);
        end
        tick;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_noresp: got %b expected 0", resp_valid);
        end
        ip_resetn = 1'b1;
        model_reset();
        set_req(2, 3'd6, 16'h5555);
        serve_one();
        checks++;
        if (last_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midreset_regrant: got %b expected 0100", last_gnt);
        end
        check_rd(3'd6, 16'h5555, "midreset_rd");
    endtask

    initial begin
        ip_resetn = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_data  = '0;
        rd_addr   = '0;
        last_gnt  = '0;
        model_reset();
        test_reset();
        test_single_write();
        test_write_once();
        test_unlocked_rewrite();
        test_round_robin();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
